// File: rtl/mmcm_usrclk_model.sv
// Behavioural stand-in for the MMCM + BUFG pair on the GTP user-clock path.
// Qualifies the input period, then replays phase-shifted output edges once per input cycle.
module mmcm_usrclk_model #(
  parameter real CLKIN_PERIOD_NS = 16.0,
  parameter int  RATIO0          = 1,
  parameter int  RATIO1          = 2,
  parameter real PHASE0_DEG      = 90.0,
  parameter real PHASE1_DEG      = 0.0,
  parameter int  LOCK_CYCLES     = 8,
  parameter real TOL_PCT         = 1.0
) (
  input  logic gtp_clk,
  input  logic rst_n,
  output logic gtp_clk_90,
  output logic gmii_clk,
  output logic pll_lock
);
  timeunit 1ns;
  timeprecision 1ps;

  if (RATIO0 < 1 || RATIO0 > 8 || RATIO1 < 1 || RATIO1 > 8) begin : gBadRatio
    $fatal(1, "mmcm_usrclk_model: RATIO0/RATIO1 must be within 1..8");
  end
  if (PHASE0_DEG < 0.0 || PHASE0_DEG >= 360.0 || PHASE1_DEG < 0.0 || PHASE1_DEG >= 360.0) begin : gBadPhase
    $fatal(1, "mmcm_usrclk_model: PHASE0_DEG/PHASE1_DEG must be within [0, 360)");
  end
  if (LOCK_CYCLES < 1) begin : gBadLock
    $fatal(1, "mmcm_usrclk_model: LOCK_CYCLES must be at least 1");
  end

  logic clk0_q      = 1'b0;
  logic clk1_q      = 1'b0;
  logic lock_q      = 1'b0;
  logic haveTs_q    = 1'b0;
  logic havePer_q   = 1'b0;
  int   epoch_q     = 0;
  int   edgeCount_q = 0;
  int   lockCount_q = 0;
  real  lastTs_q    = 0.0;
  real  lastPer_q   = 0.0;
  real  lastMeas_q  = 0.0;

  assign gtp_clk_90 = clk0_q;
  assign gmii_clk   = clk1_q;
  assign pll_lock   = lock_q;

  function automatic logic periodGood(input real period);
    real nomDev;
    real cycDev;
    nomDev = (period > CLKIN_PERIOD_NS) ? period - CLKIN_PERIOD_NS : CLKIN_PERIOD_NS - period;
    cycDev = (period > lastPer_q) ? period - lastPer_q : lastPer_q - period;
    return (nomDev <= 0.1 * CLKIN_PERIOD_NS) &&
           (!havePer_q || cycDev <= TOL_PCT / 100.0 * lastPer_q);
  endfunction

  // Bumping the epoch orphans every pending edge and watchdog process.
  task automatic haltOutputs();
    epoch_q     = epoch_q + 1;
    lock_q      = 1'b0;
    clk0_q      = 1'b0;
    clk1_q      = 1'b0;
    lockCount_q = 0;
    havePer_q   = 1'b0;
  endtask

  task automatic driveOut(input logic sel, input logic val);
    if (sel) clk1_q = val;
    else     clk0_q = val;
  endtask

  task automatic emitOutput(input logic sel, input real period, input int ratio,
                            input real phaseDeg, input int ep);
    real offs;
    offs = phaseDeg / 360.0 * period;
    if (offs > 0.0) #(offs);
    for (int n = 0; n < ratio; n++) begin
      if (n > 0) #(period / 2.0);
      if (ep != epoch_q) return;
      driveOut(sel, 1'b1);
      #(period / 2.0);
      if (ep != epoch_q) return;
      driveOut(sel, 1'b0);
    end
  endtask

  task automatic watchdog(input real limit, input int ep, input int edgeId);
    #(limit);
    if (ep == epoch_q && edgeId == edgeCount_q) haltOutputs();
  endtask

  task automatic handleEdge();
    real period;
    int  lockCount_d;
    edgeCount_q = edgeCount_q + 1;
    if (!rst_n) begin
      haltOutputs();
      haveTs_q = 1'b0;
    end else if (!haveTs_q) begin
      haveTs_q = 1'b1;
      lastTs_q = $realtime;
    end else begin
      period     = $realtime - lastTs_q;
      lastTs_q   = $realtime;
      lastMeas_q = period;
      if (periodGood(period)) begin
        lastPer_q   = period;
        havePer_q   = 1'b1;
        lockCount_d = (lockCount_q < LOCK_CYCLES) ? lockCount_q + 1 : lockCount_q;
        lockCount_q = lockCount_d;
        if (lockCount_d >= LOCK_CYCLES) lock_q = 1'b1;
      end else begin
        haltOutputs();
      end
      // Each window's edges run as independent processes so spill-over falls overlap the next window.
      if (lock_q) begin
        fork
          emitOutput(1'b0, lastPer_q / real'(RATIO0), RATIO0, PHASE0_DEG, epoch_q);
          emitOutput(1'b1, lastPer_q / real'(RATIO1), RATIO1, PHASE1_DEG, epoch_q);
        join_none
      end
      fork
        watchdog(1.5 * lastMeas_q, epoch_q, edgeCount_q);
      join_none
    end
  endtask

  always begin
    @(posedge gtp_clk);
    handleEdge();
  end

endmodule

// File: tb/tb_mmcm_usrclk_model.sv
// Self-checking bench for mmcm_usrclk_model: directed lock/unlock scenarios plus
// randomized input periods checked against a period-rule reference model.
module tb_mmcm_usrclk_model;
  timeunit 1ns;
  timeprecision 1ps;

  localparam real NOM_NS   = 16.0;
  localparam int  LOCK_N   = 8;
  localparam real TOL_FRAC = 0.01;

  logic gtp_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic clk90A, gmiiA, lockA;
  logic clk90B, gmiiB, lockB;

  int passCount  = 0;
  int checkCount = 0;

  logic mHaveTs   = 1'b0;
  logic mHavePrev = 1'b0;
  real  mLastT    = 0.0;
  real  mPrevPer  = 0.0;
  int   mStreak   = 0;

  real gtpRiseT      = 0.0;
  real gmiiRiseT     = 0.0;
  real gmiiPrevRiseT = 0.0;
  real gmiiFallT     = 0.0;
  real clk90RiseT    = 0.0;

  mmcm_usrclk_model dutA (
    .gtp_clk   (gtp_clk),
    .rst_n     (rst_n),
    .gtp_clk_90(clk90A),
    .gmii_clk  (gmiiA),
    .pll_lock  (lockA)
  );

  mmcm_usrclk_model #(.RATIO1(4), .PHASE1_DEG(180.0)) dutB (
    .gtp_clk   (gtp_clk),
    .rst_n     (rst_n),
    .gtp_clk_90(clk90B),
    .gmii_clk  (gmiiB),
    .pll_lock  (lockB)
  );

  always @(posedge gtp_clk) gtpRiseT <= $realtime;
  always @(posedge gmiiA) begin
    gmiiPrevRiseT <= gmiiRiseT;
    gmiiRiseT     <= $realtime;
  end
  always @(negedge gmiiA) gmiiFallT <= $realtime;
  always @(posedge clk90A) clk90RiseT <= $realtime;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic checkValue(input string tag, input int obs, input int exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: lock holds once LOCK_N consecutive periods obey the nominal window
  // and, after the first one, the cycle-to-cycle tolerance.
  function automatic logic modelEdge(input logic rstLow, input real now);
    real per;
    logic good;
    if (rstLow) begin
      mHaveTs = 1'b0; mHavePrev = 1'b0; mStreak = 0;
      return 1'b0;
    end
    if (!mHaveTs) begin
      mHaveTs = 1'b1; mLastT = now;
      return mStreak >= LOCK_N;
    end
    per    = now - mLastT;
    mLastT = now;
    good = (per >= 0.9 * NOM_NS) && (per <= 1.1 * NOM_NS) &&
           (!mHavePrev || (per >= (1.0 - TOL_FRAC) * mPrevPer && per <= (1.0 + TOL_FRAC) * mPrevPer));
    if (good) begin
      mHavePrev = 1'b1; mPrevPer = per; mStreak++;
    end else begin
      mHavePrev = 1'b0; mStreak = 0;
    end
    return mStreak >= LOCK_N;
  endfunction

  function automatic logic waveVal(input real x, input real p, input real d);
    real ph;
    ph = x - d;
    ph = ph - p * $floor(ph / p);
    return ph < p / 2.0;
  endfunction

  // One input cycle starting with its rising edge; rst_n changes at the falling edge.
  task automatic applyStimulus(input real per, input logic nextRst, input string tag, output logic expLock);
    gtp_clk = 1'b1;
    expLock = modelEdge(!rst_n, $realtime);
    #1;
    checkOutput({tag, " lockA"}, lockA, expLock);
    checkOutput({tag, " lockB"}, lockB, expLock);
    if (!expLock) begin
      checkOutput({tag, " idle gmiiA"}, gmiiA, 1'b0);
      checkOutput({tag, " idle clk90A"}, clk90A, 1'b0);
      checkOutput({tag, " idle gmiiB"}, gmiiB, 1'b0);
    end else begin
      checkOutput({tag, " run gmiiA"}, gmiiA, 1'b1);
      checkOutput({tag, " run clk90A"}, clk90A, 1'b0);
      checkOutput({tag, " run gmiiB"}, gmiiB, 1'b0);
    end
    #(per / 2.0 - 1.0);
    gtp_clk = 1'b0;
    rst_n   = nextRst;
    #(per / 2.0);
  endtask

  task automatic sampleWave(input real x);
    checkOutput($sformatf("wave gmiiA @%0.1f", x), gmiiA, waveVal(x, 8.0, 0.0));
    checkOutput($sformatf("wave clk90A @%0.1f", x), clk90A, waveVal(x, 16.0, 4.0));
    checkOutput($sformatf("wave gmiiB @%0.1f", x), gmiiB, waveVal(x, 4.0, 2.0));
  endtask

  task automatic checkWave();
    logic expLock;
    gtp_clk = 1'b1;
    expLock = modelEdge(!rst_n, $realtime);
    #1; checkOutput("wave lockA", lockA, expLock); sampleWave(1.0);
    #2; sampleWave(3.0);
    #2; sampleWave(5.0);
    #2; sampleWave(7.0);
    #1; gtp_clk = 1'b0;
    #1; sampleWave(9.0);
    #2; sampleWave(11.0);
    #2; sampleWave(13.0);
    #3;
  endtask

  initial begin
    logic expLock;
    int   firstLock;
    real  per;

    #0.5;
    checkOutput("time0 lockA", lockA, 1'b0);
    checkOutput("time0 gmiiA", gmiiA, 1'b0);
    checkOutput("time0 clk90A", clk90A, 1'b0);
    #0.5;

    for (int i = 1; i <= 4; i++) applyStimulus(16.0, (i == 4), "reset", expLock);
    firstLock = -1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(16.0, 1'b1, "acquire", expLock);
      if (lockA && firstLock < 0) firstLock = k;
    end
    checkValue("lock latency edges", firstLock, LOCK_N);

    checkWave();
    checkWave();
    checkOutput("gmii period 8ns", (gmiiRiseT - gmiiPrevRiseT > 7.999) && (gmiiRiseT - gmiiPrevRiseT < 8.001), 1'b1);
    checkOutput("gmii high 4ns", (gmiiFallT - gmiiRiseT > 3.999) && (gmiiFallT - gmiiRiseT < 4.001), 1'b1);
    checkOutput("clk90 offset 4ns", (clk90RiseT - gtpRiseT > 3.999) && (clk90RiseT - gtpRiseT < 4.001), 1'b1);

    applyStimulus(16.0, 1'b0, "pre-reset", expLock);
    applyStimulus(16.0, 1'b1, "locked reset", expLock);
    checkOutput("reset drops lock", lockA, 1'b0);
    firstLock = -1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(16.0, 1'b1, "reacquire", expLock);
      if (lockA && firstLock < 0) firstLock = k;
    end
    checkValue("relock after reset edges", firstLock, LOCK_N);

    gtp_clk = 1'b1;
    expLock = modelEdge(!rst_n, $realtime);
    #1;    checkOutput("wd last edge lock", lockA, expLock);
    #7;    gtp_clk = 1'b0;
    #15.5; checkOutput("wd before limit", lockA, 1'b1);
    #1;    checkOutput("wd after limit lockA", lockA, 1'b0);
    checkOutput("wd after limit lockB", lockB, 1'b0);
    checkOutput("wd gmiiA", gmiiA, 1'b0);
    checkOutput("wd clk90A", clk90A, 1'b0);
    mStreak = 0; mHavePrev = 1'b0;
    #15.5;
    firstLock = -1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(16.0, 1'b1, "wd restart", expLock);
      if (lockA && firstLock < 0) firstLock = k;
    end
    checkValue("relock after stall edges", firstLock, LOCK_N);

    applyStimulus(16.1, 1'b1, "jitter", expLock);
    applyStimulus(16.0, 1'b1, "jitter", expLock);
    applyStimulus(17.0, 1'b1, "jitter", expLock);
    checkOutput("jitter 0.6pct keeps lock", lockA, 1'b1);
    applyStimulus(16.0, 1'b1, "stretch", expLock);
    checkOutput("stretch 6pct unlocks", lockA, 1'b0);
    for (int k = 0; k < 9; k++) applyStimulus(16.0, 1'b1, "stretch relock", expLock);
    checkOutput("stretch relocked", lockA, 1'b1);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) < 8) per = 15.95 + 0.01 * real'($urandom_range(0, 10));
      else begin
        case ($urandom_range(0, 2))
          0:       per = 12.0;
          1:       per = 17.5;
          default: per = 19.0;
        endcase
      end
      applyStimulus(per, 1'b1, "random", expLock);
    end

    applyStimulus(16.0, 1'b0, "slow pre-reset", expLock);
    applyStimulus(16.0, 1'b1, "slow reset", expLock);
    for (int k = 0; k < 12; k++) applyStimulus(20.0, 1'b1, "slow input", expLock);
    checkOutput("slow input never locks", lockA, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
